add_tree_gather: RTL and testbench

// - Producer side of the 8-input adder tree: gathers a serial stream of

---
 rtl/add_tree_gather_if.sv | 34 +++
 rtl/add_tree_gather.sv | 87 ++++++++
 tb/tb_add_tree_gather.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_tree_gather_if.sv
// Stream-in / vector-out bundle for the adder-tree gather stage.
// in_last exists only when ADD_TREE_GATHER_PAD_EN is defined.
interface add_tree_gather_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
`ifdef ADD_TREE_GATHER_PAD_EN
  logic             in_last;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data [LANES];

  modport slave (
    input  in_valid,
`ifdef ADD_TREE_GATHER_PAD_EN
    input  in_last,
`endif
    input  in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid,
`ifdef ADD_TREE_GATHER_PAD_EN
    output in_last,
`endif
    output in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/add_tree_gather.sv
// Gathers a serial word stream into LANES-wide vectors (staging + output reg).
// ADD_TREE_GATHER_PAD_EN: in_last closes a short vector, zero-padding the rest.
module add_tree_gather #(
  parameter int WIDTH = 16,
  parameter int LANES = 8
) (
  input logic            clk,
  input logic            rst,
  add_tree_gather_if.slave bus
);
  localparam int CW = $clog2(LANES);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] stage_q [LANES-1];
  logic [WIDTH-1:0] stage_d [LANES-1];
  logic [WIDTH-1:0] out_q   [LANES];
  logic [WIDTH-1:0] out_d   [LANES];
  logic             out_valid_q, out_valid_d;
  logic             last_w;
  logic             complete;
  logic             in_ready;
  logic             accept;

`ifdef ADD_TREE_GATHER_PAD_EN
  assign last_w = bus.in_last;
`else
  assign last_w = 1'b0;
`endif

  assign complete = (count_q == LAST) || last_w;
  // A completing word may enter in the same cycle the held vector drains.
  assign in_ready = !rst &&
    (!complete || !out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    count_d     = count_q;
    stage_d     = stage_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (complete) begin
        count_d     = '0;
        out_valid_d = 1'b1;
        for (int i = 0; i < LANES - 1; i++) begin
          if (CW'(i) < count_q) begin
            out_d[i] = stage_q[i];
          end else if (CW'(i) == count_q) begin
            out_d[i] = bus.in_data;
          end else begin
            out_d[i] = '0;
          end
        end
        out_d[LANES-1] = (count_q == LAST) ? bus.in_data : '0;
      end else begin
        count_d = count_q + CW'(1);
        for (int i = 0; i < LANES - 1; i++) begin
          if (CW'(i) == count_q) begin
            stage_d[i] = bus.in_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      stage_q     <= '{default: '0};
      out_q       <= '{default: '0};
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      stage_q     <= stage_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
endmodule

// File: tb/tb_add_tree_gather.sv
// Directed + random-stress bench for add_tree_gather (WIDTH=16, LANES=8).
// Inputs change at negedge; outputs are sampled 1 time unit later.
module tb_add_tree_gather;
  localparam int W = 16;
  localparam int L = 8;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic [L*W-1:0] cap [$];
  logic [L*W-1:0] expq [$];

  add_tree_gather_if #(.WIDTH(W), .LANES(L)) bus ();

  add_tree_gather #(.WIDTH(W), .LANES(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [L*W-1:0] got,
                       input logic [L*W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [L*W-1:0] pack_out();
    logic [L*W-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = bus.out_data[i];
    return v;
  endfunction

  function automatic logic [L*W-1:0] mkvec(input int base);
    logic [L*W-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = W'(base + i);
    return v;
  endfunction

  task automatic step(output bit acc);
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (!rst && bus.out_valid && bus.out_ready) cap.push_back(pack_out());
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] d);
    bit acc;
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int ptr;
    int stalls;
    int nw;
    int lane;
    int cyc;
    logic [L*W-1:0] cur;
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef ADD_TREE_GATHER_PAD_EN
    bus.in_last = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", pack_out(), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1..8 back-to-back, consumer always ready
    cap.delete();
    bus.out_ready = 1'b1;
    for (int w = 1; w <= 8; w++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'(w);
      step(acc);
      check("b2b_acc", acc, 1);
    end
    bus.in_valid = 1'b0;
    #1;
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_data", pack_out(), mkvec(1));
    step(acc);
    #1;
    check("b2b_valid_drop", bus.out_valid, 0);
    check("b2b_count", cap.size(), 1);

    // 16 words, consumer blocked until cycle 20
    @(negedge clk);
    cap.delete();
    ptr = 0;
    stalls = 0;
    for (int c = 0; c < 24; c++) begin
      bus.out_ready = (c >= 20);
      bus.in_valid  = (ptr < 16);
      bus.in_data   = W'(16 + ptr);
      #1;
      if (c == 8) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_first", pack_out(), mkvec(16));
      end
      if (c == 19) check("hold_stable", pack_out(), mkvec(16));
      if (c == 21) begin
        check("ovl_valid", bus.out_valid, 1);
        check("ovl_data", pack_out(), mkvec(24));
      end
      if (c == 22) check("ovl_drain", bus.out_valid, 0);
      step(acc);
      if (acc) ptr++;
      else if (bus.in_valid) stalls++;
    end
    check("hold_stalls", stalls, 5);
    check("hold_words", ptr, 16);
    check("hold_nvec", cap.size(), 2);
    if (cap.size() == 2) begin
      check("hold_vec0", cap[0], mkvec(16));
      check("hold_vec1", cap[1], mkvec(24));
    end

    // reset in the middle of a vector
    cap.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(W'(16'h50 + i));
    rst = 1'b1;
    bus.in_data = 16'h99;
    #1;
    check("mid_rst_ready", bus.in_ready, 0);
    step(acc);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send(W'(16'hA0 + i));
    bus.in_valid = 1'b0;
    repeat (3) step(acc);
    check("mid_rst_nvec", cap.size(), 1);
    if (cap.size() == 1) check("mid_rst_vec", cap[0], mkvec(16'hA0));

`ifdef ADD_TREE_GATHER_PAD_EN
    cap.delete();
    send(16'd7);
    send(16'd8);
    bus.in_last = 1'b1;
    send(16'd9);
    bus.in_last = 1'b0;
    for (int i = 0; i < 8; i++) send(W'(16'h30 + i));
    bus.in_valid = 1'b0;
    repeat (3) step(acc);
    check("pad_nvec", cap.size(), 2);
    if (cap.size() == 2) begin
      check("pad_vec", cap[0],
        128'h0000_0000_0000_0000_0000_0009_0008_0007);
      check("pad_next", cap[1], mkvec(16'h30));
    end
`endif

    // random valid/ready stress, 1000 words
    cap.delete();
    expq.delete();
    nw = 0;
    lane = 0;
    cyc = 0;
    cur = '0;
    while (nw < 1000 && cyc < 20000) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = W'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      step(acc);
      cyc++;
      if (acc) begin
        cur[lane*W +: W] = bus.in_data;
        nw++;
        lane++;
        if (lane == L) begin
          expq.push_back(cur);
          cur = '0;
          lane = 0;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step(acc);
    check("stress_words", nw, 1000);
    check("stress_nvec", cap.size(), expq.size());
    for (int i = 0; i < expq.size() && i < cap.size(); i++) begin
      check("stress_vec", cap[i], expq[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
